// File: rtl/morse_rx_ctrl.sv
// morse_rx_ctrl: key-line sampler and symbol sequencer for the de decoder.
// Classifies presses, closes letters on a gap, hands letters downstream.
module morse_rx_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MIN_PRESS  = 2,
  parameter int DOT_MAX    = 4,
  parameter int LETTER_GAP = 8,
  parameter int DE_LAT     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [3:0] de_morse,
  output logic [2:0] de_num,
  input  logic [4:0] de_out,
  output logic [4:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    GAP,
    LOOKUP,
    HOLD,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] DOT_C   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(DE_LAT);

  state_t           state;
  state_t           state_nx;
  logic             k1;
  logic             key_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       sym;
  logic [3:0]       sym_nx;
  logic [2:0]       num;
  logic [2:0]       num_nx;
  logic [1:0]       pos;
  logic             err_nx;
  logic             cap;
  logic             in_dec;

  // two-flop synchronizer for the asynchronous key line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k1    <= 1'b0;
      key_s <= 1'b0;
    end else begin
      k1    <= key_in;
      key_s <= k1;
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + ONE_C;

  // state, counter, symbol buffer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sym      <= '0;
      num      <= '0;
      err      <= 1'b0;
      char_out <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sym   <= sym_nx;
      num   <= num_nx;
      err   <= err_nx;
      if (cap) char_out <= de_out;
    end
  end

  // next-state logic; in GAP the counter holds key-low cycles
  // including the release cycle, so LETTER_GAP lows close a letter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sym_nx   = sym;
    num_nx   = num;
    err_nx   = 1'b0;
    cap      = 1'b0;
    pos      = 2'd3 - num[1:0];
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (key_s) begin
          state_nx = PRESS;
          cnt_nx   = ONE_C;
        end
      end
      PRESS: begin
        if (key_s) begin
          cnt_nx = cnt_inc;
        end else if (cnt < MIN_C) begin
          cnt_nx   = ONE_C;
          state_nx = (num == 3'd0) ? IDLE : GAP;
        end else if (num == 3'd4) begin
          err_nx   = 1'b1;
          sym_nx   = '0;
          num_nx   = '0;
          cnt_nx   = '0;
          state_nx = DRAIN;
        end else begin
          sym_nx[pos] = (cnt > DOT_C);
          num_nx      = num + 3'd1;
          cnt_nx      = ONE_C;
          state_nx    = GAP;
        end
      end
      GAP: begin
        if (key_s) begin
          state_nx = PRESS;
          cnt_nx   = ONE_C;
        end else if (cnt_inc >= GAP_C) begin
          state_nx = LOOKUP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      LOOKUP: begin
        if (cnt >= LAT_C) begin
          cap      = 1'b1;
          cnt_nx   = '0;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      HOLD: begin
        if (char_ready) begin
          sym_nx   = '0;
          num_nx   = '0;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        cnt_nx = '0;
        if (!key_s) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign in_dec     = (state == LOOKUP) || (state == HOLD);
  assign de_morse   = in_dec ? sym : 4'd0;
  assign de_num     = in_dec ? num : 3'd0;
  assign char_valid = (state == HOLD);

endmodule

// File: tb/tb_morse_rx_ctrl.sv
// tb_morse_rx_ctrl: table-driven letters plus hold and reset sequences.
// A small registered decoder model stands in for de.
module tb_morse_rx_ctrl;

  localparam int DE_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       char_ready;
  logic [3:0] de_morse;
  logic [2:0] de_num;
  logic [4:0] de_out = 5'd0;
  logic [4:0] char_out;
  logic       char_valid;
  logic       err;

  int total = 0;
  int bad   = 0;

  morse_rx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .de_morse   (de_morse),
    .de_num     (de_num),
    .de_out     (de_out),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] letter(input logic [3:0] m,
                                        input logic [2:0] n);
    case ({n, m})
      {3'd1, 4'b0000}: return 5'd4;
      {3'd1, 4'b1000}: return 5'd19;
      {3'd2, 4'b0000}: return 5'd8;
      {3'd4, 4'b1010}: return 5'd2;
      default:         return 5'd31;
    endcase
  endfunction

  // decoder model with one cycle of latency
  always @(posedge clk) de_out <= letter(de_morse, de_num);

  int         cyc = 0;
  int         err_cnt;
  int         vcnt;
  int         num_cyc;
  int         val_cyc;
  logic       seen_num;
  logic       seen_val;
  logic       prev_v = 1'b0;
  logic [3:0] g_m;
  logic [2:0] g_n;
  logic [4:0] g_c;

  // event monitor sampled on the falling edge
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (de_num != 3'd0 && !seen_num) begin
      seen_num = 1'b1;
      g_m      = de_morse;
      g_n      = de_num;
      num_cyc  = cyc;
    end
    if (char_valid === 1'b1 && !prev_v) vcnt++;
    if (char_valid === 1'b1 && !seen_val) begin
      seen_val = 1'b1;
      g_c      = char_out;
      val_cyc  = cyc;
    end
    prev_v = char_valid;
    cyc++;
  end

  task automatic clear_mon();
    err_cnt  = 0;
    vcnt     = 0;
    num_cyc  = 0;
    val_cyc  = 0;
    seen_num = 1'b0;
    seen_val = 1'b0;
    g_m      = '0;
    g_n      = '0;
    g_c      = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic k, input int n);
    key_in = k;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (char_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int         ns;
    int         pl[6];
    int         gl[6];
    logic [3:0] m;
    logic [2:0] n;
    logic [4:0] c;
    int         nv;
    int         ne;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];
  logic ok;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4, '{6, 3, 6, 3, 0, 0}, '{2, 2, 2, 8, 0, 0},
              4'b1010, 3'd4, 5'd2, 1, 0};
    vt[1] = '{1, '{3, 0, 0, 0, 0, 0}, '{8, 0, 0, 0, 0, 0},
              4'b0000, 3'd1, 5'd4, 1, 0};
    vt[2] = '{2, '{1, 5, 0, 0, 0, 0}, '{2, 8, 0, 0, 0, 0},
              4'b1000, 3'd1, 5'd19, 1, 0};
    vt[3] = '{1, '{2, 0, 0, 0, 0, 0}, '{8, 0, 0, 0, 0, 0},
              4'b0000, 3'd1, 5'd4, 1, 0};
    vt[4] = '{1, '{4, 0, 0, 0, 0, 0}, '{8, 0, 0, 0, 0, 0},
              4'b0000, 3'd1, 5'd4, 1, 0};
    vt[5] = '{1, '{5, 0, 0, 0, 0, 0}, '{8, 0, 0, 0, 0, 0},
              4'b1000, 3'd1, 5'd19, 1, 0};
    vt[6] = '{6, '{2, 2, 2, 2, 2, 5}, '{2, 2, 2, 2, 2, 8},
              4'b1000, 3'd1, 5'd19, 1, 1};
    vt[7] = '{2, '{2, 2, 0, 0, 0, 0}, '{7, 8, 0, 0, 0, 0},
              4'b0000, 3'd2, 5'd8, 1, 0};
    vt[8] = '{2, '{2, 2, 0, 0, 0, 0}, '{16, 8, 0, 0, 0, 0},
              4'b0000, 3'd1, 5'd4, 2, 0};

    rst        = 1'b1;
    key_in     = 1'b0;
    char_ready = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst de_morse", de_morse, 0);
    chk("rst de_num", de_num, 0);
    chk("rst char_out", char_out, 0);
    chk("rst char_valid", char_valid, 0);
    chk("rst err", err, 0);
    rst = 1'b0;
    drive(0, 4);

    char_ready = 1'b1;
    for (int v = 0; v < NV; v++) begin
      clear_mon();
      for (int i = 0; i < vt[v].ns; i++) begin
        drive(1, vt[v].pl[i]);
        drive(0, vt[v].gl[i]);
      end
      drive(0, 24);
      chk($sformatf("v%0d letters", v), vcnt, vt[v].nv);
      chk($sformatf("v%0d err", v), err_cnt, vt[v].ne);
      if (vt[v].nv > 0) begin
        chk($sformatf("v%0d de_morse", v), g_m, vt[v].m);
        chk($sformatf("v%0d de_num", v), g_n, vt[v].n);
        chk($sformatf("v%0d char_out", v), g_c, vt[v].c);
        chk($sformatf("v%0d latency", v), val_cyc - num_cyc,
            DE_LAT + 1);
      end
    end

    char_ready = 1'b0;
    clear_mon();
    drive(1, 3);
    drive(0, 8);
    wait_valid(30, ok);
    chk("hold wait", ok, 1);
    chk("hold char", char_out, 5'd4);
    for (int i = 0; i < 10; i++) begin
      key_in = (i >= 1 && i <= 5);
      @(posedge clk);
      #1;
      chk($sformatf("hold valid %0d", i), char_valid, 1);
      chk($sformatf("hold char %0d", i), char_out, 5'd4);
      chk($sformatf("hold num %0d", i), de_num, 3'd1);
    end
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("xfer valid", char_valid, 0);
    chk("xfer de_num", de_num, 0);
    drive(0, 24);
    chk("hold letters", vcnt, 1);

    clear_mon();
    drive(1, 3);
    drive(0, 2);
    drive(1, 4);
    rst = 1'b1;
    #1;
    chk("rst press de_num", de_num, 0);
    chk("rst press de_morse", de_morse, 0);
    chk("rst press char_out", char_out, 0);
    chk("rst press valid", char_valid, 0);
    chk("rst press err", err, 0);
    key_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    drive(0, 24);
    chk("rst press letters", vcnt, 0);

    char_ready = 1'b0;
    drive(1, 5);
    drive(0, 8);
    wait_valid(30, ok);
    chk("hold2 wait", ok, 1);
    chk("hold2 char", char_out, 5'd19);
    rst = 1'b1;
    #1;
    chk("rst hold valid", char_valid, 0);
    chk("rst hold de_num", de_num, 0);
    chk("rst hold de_morse", de_morse, 0);
    chk("rst hold char_out", char_out, 0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    char_ready = 1'b1;
    clear_mon();
    drive(0, 24);
    chk("rst hold letters", vcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
